// File: rtl/rr_banked_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_banked_select
// Description : Banked round-robin select stage. For each issue class, picks
//               up to GRANT_NUM ready entries from an ENTRY_NUM-entry issue
//               queue, one per interleaved bank (bank = entry mod GRANT_NUM),
//               each (class, bank) pair with its own rotating priority
//               pointer. Grants are registered with stall/flush handling.
//               Optional macro RSD_SELECT_GRANT_MASK_EN masks entries granted
//               on the previous cycle out of the next arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_banked_select #(
  parameter int ENTRY_NUM = 16,
  parameter int GRANT_NUM = 2,
  parameter int CLASS_NUM = 4,
  parameter int IDX_W     = $clog2(ENTRY_NUM),
  parameter int BANK_SIZE = ENTRY_NUM / GRANT_NUM
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ENTRY_NUM-1:0]                 op_ready,
  input  logic [CLASS_NUM*ENTRY_NUM-1:0]       issue_req,
  input  logic                                 stall,
  input  logic                                 flush,
  output logic [CLASS_NUM*GRANT_NUM-1:0]       sel_valid,
  output logic [CLASS_NUM*GRANT_NUM*IDX_W-1:0] sel_ptr,
  output logic [CLASS_NUM*ENTRY_NUM-1:0]       sel_vector,
  output logic                                 any_valid
);

  localparam int PTR_W    = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
  localparam int LANE_NUM = CLASS_NUM * GRANT_NUM;

  // Entries excluded from arbitration this cycle (grant mask or nothing)
  logic [ENTRY_NUM-1:0]                 w_block;
  // Effective requests after ready gating and class priority
  logic [CLASS_NUM*ENTRY_NUM-1:0]       w_eff;
  logic [ENTRY_NUM-1:0]                 w_claimed;
  // Next-state grant information gathered from every lane
  logic [LANE_NUM-1:0]                  w_valid_nxt;
  logic [LANE_NUM*IDX_W-1:0]            w_ptr_nxt;
  logic [LANE_NUM*ENTRY_NUM-1:0]        w_lane_vec;
  logic [CLASS_NUM*ENTRY_NUM-1:0]       w_vec_nxt;

  // Output registers
  logic [LANE_NUM-1:0]                  r_valid;
  logic [LANE_NUM*IDX_W-1:0]            r_ptr_out;
  logic [CLASS_NUM*ENTRY_NUM-1:0]       r_vec;
  logic                                 r_any;

  // Only a plain, unstalled, unflushed cycle consumes the new grants
  logic w_advance;
  assign w_advance = ~flush & ~stall;

`ifdef RSD_SELECT_GRANT_MASK_EN
  // Union over classes of the grants being loaded this cycle
  logic [ENTRY_NUM-1:0] w_union_nxt;
  logic [ENTRY_NUM-1:0] r_mask;

  // Collapse per-class grant vectors into one entry mask
  always_comb begin
    w_union_nxt = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      w_union_nxt = w_union_nxt | w_vec_nxt[c*ENTRY_NUM +: ENTRY_NUM];
    end
  end

  // Mask tracks the registered grant union, covering the invalidate latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= '0;
    end else if (flush) begin
      r_mask <= '0;
    end else if (!stall) begin
      r_mask <= w_union_nxt;
    end
  end

  assign w_block = r_mask;
`else
  assign w_block = '0;
`endif

  // Lower class index claims an entry that several classes request
  always_comb begin
    w_eff     = '0;
    w_claimed = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      for (int c = 0; c < CLASS_NUM; c++) begin
        w_eff[c*ENTRY_NUM + e] = op_ready[e] & issue_req[c*ENTRY_NUM + e]
                                 & ~w_claimed[e] & ~w_block[e];
        w_claimed[e] = w_claimed[e] | issue_req[c*ENTRY_NUM + e];
      end
    end
  end

  generate
    for (genvar gc = 0; gc < CLASS_NUM; gc++) begin : g_class
      for (genvar gb = 0; gb < GRANT_NUM; gb++) begin : g_bank
        localparam int LANE = gc * GRANT_NUM + gb;

        logic [BANK_SIZE-1:0] bank_req;
        logic                 found;
        logic [PTR_W-1:0]     loc;
        logic [PTR_W:0]       scan;
        logic [PTR_W-1:0]     scan_idx;
        logic [PTR_W-1:0]     ptr_inc;
        logic [IDX_W-1:0]     abs_idx;
        logic [PTR_W-1:0]     r_rr_ptr;

        // Gather this bank's requests in local-index order
        always_comb begin
          bank_req = '0;
          for (int l = 0; l < BANK_SIZE; l++) begin
            bank_req[l] = w_eff[gc*ENTRY_NUM + l*GRANT_NUM + gb];
          end
        end

        // Scan from the pointer upward, wrapping, and take the first hit
        always_comb begin
          found    = 1'b0;
          loc      = '0;
          scan     = '0;
          scan_idx = '0;
          for (int k = 0; k < BANK_SIZE; k++) begin
            scan = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (scan >= (PTR_W+1)'(BANK_SIZE)) begin
              scan = scan - (PTR_W+1)'(BANK_SIZE);
            end
            scan_idx = scan[PTR_W-1:0];
            if (!found && bank_req[scan_idx]) begin
              found = 1'b1;
              loc   = scan_idx;
            end
          end
        end

        // Successor of the granted slot, wrapping at the end of the bank
        always_comb begin
          if (loc == PTR_W'(BANK_SIZE - 1)) begin
            ptr_inc = '0;
          end else begin
            ptr_inc = loc + PTR_W'(1);
          end
        end

        assign abs_idx = IDX_W'(loc) * IDX_W'(GRANT_NUM) + IDX_W'(gb);

        assign w_valid_nxt[LANE]                  = found;
        assign w_ptr_nxt[LANE*IDX_W +: IDX_W]     = found ? abs_idx : '0;
        assign w_lane_vec[LANE*ENTRY_NUM +: ENTRY_NUM] =
          found ? (ENTRY_NUM'(1) << abs_idx) : '0;

        // Priority pointer moves past the winner only on a consumed grant
        always_ff @(posedge clk) begin
          if (!rst) begin
            r_rr_ptr <= '0;
          end else if (w_advance && found) begin
            r_rr_ptr <= ptr_inc;
          end
        end
      end
    end
  endgenerate

  // Merge the per-bank one-hot grants into one vector per class
  always_comb begin
    w_vec_nxt = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      for (int b = 0; b < GRANT_NUM; b++) begin
        w_vec_nxt[c*ENTRY_NUM +: ENTRY_NUM] = w_vec_nxt[c*ENTRY_NUM +: ENTRY_NUM]
          | w_lane_vec[(c*GRANT_NUM + b)*ENTRY_NUM +: ENTRY_NUM];
      end
    end
  end

  // Output registers: reset, then flush kill, then stall hold, then load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= '0;
      r_ptr_out <= '0;
      r_vec     <= '0;
      r_any     <= 1'b0;
    end else if (flush) begin
      r_valid   <= '0;
      r_ptr_out <= '0;
      r_vec     <= '0;
      r_any     <= 1'b0;
    end else if (!stall) begin
      r_valid   <= w_valid_nxt;
      r_ptr_out <= w_ptr_nxt;
      r_vec     <= w_vec_nxt;
      r_any     <= |w_valid_nxt;
    end
  end

  assign sel_valid  = r_valid;
  assign sel_ptr    = r_ptr_out;
  assign sel_vector = r_vec;
  assign any_valid  = r_any;

endmodule
`default_nettype wire

// File: tb/tb_rr_banked_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_banked_select
// Description : Directed self-checking bench for rr_banked_select with
//               ENTRY_NUM=8, GRANT_NUM=2, CLASS_NUM=2. Expectations for the
//               alternate-cycle grant scenario follow RSD_SELECT_GRANT_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_banked_select;

  localparam int ENTRY_NUM = 8;
  localparam int GRANT_NUM = 2;
  localparam int CLASS_NUM = 2;
  localparam int IDX_W     = 3;

  logic                                 clk;
  logic                                 rst;
  logic [ENTRY_NUM-1:0]                 op_ready;
  logic [CLASS_NUM*ENTRY_NUM-1:0]       issue_req;
  logic                                 stall;
  logic                                 flush;
  logic [CLASS_NUM*GRANT_NUM-1:0]       sel_valid;
  logic [CLASS_NUM*GRANT_NUM*IDX_W-1:0] sel_ptr;
  logic [CLASS_NUM*ENTRY_NUM-1:0]       sel_vector;
  logic                                 any_valid;

  int   checks;
  int   errors;
  logic conflict_chk;

  rr_banked_select #(
    .ENTRY_NUM (ENTRY_NUM),
    .GRANT_NUM (GRANT_NUM),
    .CLASS_NUM (CLASS_NUM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_ready   (op_ready),
    .issue_req  (issue_req),
    .stall      (stall),
    .flush      (flush),
    .sel_valid  (sel_valid),
    .sel_ptr    (sel_ptr),
    .sel_vector (sel_vector),
    .any_valid  (any_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    if (conflict_chk && rst) begin
      checks++;
      assert ((issue_req[15:8] & issue_req[7:0]) === 8'h00)
      else begin
        errors++;
        $error("FAIL class_conflict: observed %0h expected 0",
               issue_req[15:8] & issue_req[7:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] v, input logic [11:0] p,
                           input logic [15:0] vec, input logic any);
    chk({tag, "_valid"}, 32'(sel_valid), 32'(v));
    chk({tag, "_ptr"}, 32'(sel_ptr), 32'(p));
    chk({tag, "_vector"}, 32'(sel_vector), 32'(vec));
    chk({tag, "_any"}, 32'(any_valid), 32'(any));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    conflict_chk = 1'b0;
    rst          = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    op_ready     = 8'hFF;
    issue_req    = 16'hFFFF;

    // Reset held for two cycles with every request asserted
    tick();
    tick();
    check_all("reset", 4'b0000, 12'h000, 16'h0000, 1'b0);

    // Class 0 requests everything: bank0 -> entry 0, bank1 -> entry 1
    conflict_chk = 1'b1;
    issue_req = 16'h00FF;
    rst = 1'b1;
    tick();
    check_all("first_grant", 4'b0011, 12'h008, 16'h0003, 1'b1);

    // Round robin over bank0 entries 0,2,4,6 then wrap to 0
    do_reset();
    issue_req = 16'h0055;
    rst = 1'b1;
    tick();
    check_all("rr0", 4'b0001, 12'h000, 16'h0001, 1'b1);
    tick();
    check_all("rr2", 4'b0001, 12'h002, 16'h0004, 1'b1);
    tick();
    check_all("rr4", 4'b0001, 12'h004, 16'h0010, 1'b1);
    tick();
    check_all("rr6", 4'b0001, 12'h006, 16'h0040, 1'b1);
    tick();
    check_all("rr_wrap", 4'b0001, 12'h000, 16'h0001, 1'b1);

    // Stall / flush: class1 entry 5 (bank1, local 2) -> pointer becomes 3
    do_reset();
    issue_req = 16'h2000;
    rst = 1'b1;
    tick();
    check_all("grant5", 4'b1000, 12'hA00, 16'h2000, 1'b1);
    stall = 1'b1;
    issue_req = 16'h8000;
    tick();
    check_all("stall1", 4'b1000, 12'hA00, 16'h2000, 1'b1);
    tick();
    check_all("stall2", 4'b1000, 12'hA00, 16'h2000, 1'b1);
    tick();
    check_all("stall3", 4'b1000, 12'hA00, 16'h2000, 1'b1);
    flush = 1'b1;
    tick();
    check_all("flush", 4'b0000, 12'h000, 16'h0000, 1'b0);
    // Requests at locals 0,2,3; a retained pointer of 3 selects entry 7
    flush = 1'b0;
    stall = 1'b0;
    issue_req = 16'hA200;
    tick();
    check_all("ptr_retained", 4'b1000, 12'hE00, 16'h8000, 1'b1);

    // Entry 3 requested by both classes: class0 wins, class1 takes entry 5
    conflict_chk = 1'b0;
    do_reset();
    issue_req = 16'h2808;
    rst = 1'b1;
    tick();
    check_all("conflict", 4'b1010, 12'hA18, 16'h2008, 1'b1);

    // Only entry 4 operand-ready: only class0 bank0 grants
    do_reset();
    issue_req = 16'hFFFF;
    op_ready = 8'h10;
    rst = 1'b1;
    tick();
    check_all("op_ready", 4'b0001, 12'h004, 16'h0010, 1'b1);

    // Entry 2 alone requests continuously
    do_reset();
    conflict_chk = 1'b1;
    op_ready = 8'hFF;
    issue_req = 16'h0004;
    rst = 1'b1;
    tick();
    check_all("mask_c1", 4'b0001, 12'h002, 16'h0004, 1'b1);
    tick();
`ifdef RSD_SELECT_GRANT_MASK_EN
    check_all("mask_c2", 4'b0000, 12'h000, 16'h0000, 1'b0);
`else
    check_all("mask_c2", 4'b0001, 12'h002, 16'h0004, 1'b1);
`endif
    tick();
    check_all("mask_c3", 4'b0001, 12'h002, 16'h0004, 1'b1);
    tick();
`ifdef RSD_SELECT_GRANT_MASK_EN
    check_all("mask_c4", 4'b0000, 12'h000, 16'h0000, 1'b0);
`else
    check_all("mask_c4", 4'b0001, 12'h002, 16'h0004, 1'b1);
`endif

    // Reset during stall and flush wins; pointer for (0,0) returns to 0
    stall = 1'b1;
    flush = 1'b1;
    rst = 1'b0;
    tick();
    check_all("rst_mid_stall", 4'b0000, 12'h000, 16'h0000, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
    issue_req = 16'h0005;
    rst = 1'b1;
    tick();
    check_all("ptr_after_rst", 4'b0001, 12'h000, 16'h0001, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
